// File: rtl/sfx_request_queue_if.sv
// Event/request bundle between the Pong sound logic, the request queue and the tone sequencer.
// The game side drives ev_valid; the queue drives everything else.
interface sfx_request_queue_if;
   logic [3:0] ev_valid;
   logic       play;
   logic [1:0] ev_code;
   logic       busy;
   logic [2:0] pending;
   logic       drop;

   modport master (
      output ev_valid,
      input  play, ev_code, busy, pending, drop
   );

   modport slave (
      input  ev_valid,
      output play, ev_code, busy, pending, drop
   );
endinterface

// File: rtl/sfx_request_queue.sv
// Buffers Pong sound events in a 4-deep FIFO and replays them one at a time as a
// timed play level followed by a silent gap; game_over flushes the queue and preempts.
module sfx_request_queue #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int HOLD_CYCLES = 200_000_000,
   parameter int GAP_CYCLES  = 10_000_000
) (
   input logic               clk_100MHz,
   input logic               reset,
   sfx_request_queue_if.slave bus
);

   // The 28-bit window counter cannot represent longer windows.
   if (CLK_FREQ < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
       HOLD_CYCLES >= 2**28 || GAP_CYCLES >= 2**28) begin : gBadParam
      $error("sfx_request_queue: illegal parameter value");
   end

   localparam logic [27:0] HoldLast = 28'(HOLD_CYCLES - 1);
   localparam logic [27:0] GapLast  = 28'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [27:0] cnt_q, cnt_d;
   logic [1:0]  rdPtr_q, rdPtr_d;
   logic [1:0]  wrPtr_q, wrPtr_d;
   logic [2:0]  count_q, count_d;
   logic [1:0]  mem_q [4];
   logic [1:0]  mem_d [4];
   logic        play_q, play_d;
   logic [1:0]  evCode_q, evCode_d;
   logic        drop_q, drop_d;

   logic        pushReq;
   logic [1:0]  pushCode;
   logic        lowerDrop;
   logic        gameOver;
   logic        popReq;
   logic        pushOk;

   // Only the highest-priority event of a cycle is kept; any extra set bit counts as a discard.
   always_comb begin
      pushReq   = |bus.ev_valid;
      pushCode  = 2'd0;
      lowerDrop = |(bus.ev_valid & (bus.ev_valid - 4'd1));
      gameOver  = bus.ev_valid[3];
      casez (bus.ev_valid)
         4'b1???: pushCode = 2'd3;
         4'b01??: pushCode = 2'd2;
         4'b001?: pushCode = 2'd1;
         default: pushCode = 2'd0;
      endcase
   end

   // A game_over in the same cycle suppresses the IDLE pop so the flush result stays coherent.
   assign popReq = (state_q == IDLE) && (count_q != 3'd0) && !gameOver;
   assign pushOk = pushReq && !gameOver && ((count_q != 3'd4) || popReq);

   // Next-state for the playback FSM and its window counter.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      play_d   = play_q;
      evCode_d = evCode_q;
      case (state_q)
         IDLE: begin
            if (popReq) begin
               evCode_d = mem_q[rdPtr_q];
               play_d   = 1'b1;
               cnt_d    = 28'd0;
               state_d  = PLAY;
            end
         end
         PLAY: begin
            if ((gameOver && evCode_q != 2'd3) || cnt_q == HoldLast) begin
               play_d  = 1'b0;
               cnt_d   = 28'd0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 28'd1;
            end
         end
         GAP: begin
            if (cnt_q == GapLast) begin
               cnt_d   = 28'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 28'd1;
            end
         end
         default: begin
            play_d  = 1'b0;
            cnt_d   = 28'd0;
            state_d = IDLE;
         end
      endcase
   end

   // FIFO bookkeeping: flush on game_over, otherwise ordinary push/pop with full-discard.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      mem_d   = mem_q;
      drop_d  = 1'b0;
      if (gameOver) begin
         rdPtr_d = wrPtr_q;
         if (state_q == PLAY && evCode_q == 2'd3) begin
            count_d = 3'd0;
            drop_d  = 1'b1;
         end else begin
            mem_d[wrPtr_q] = 2'd3;
            wrPtr_d        = wrPtr_q + 2'd1;
            count_d        = 3'd1;
            drop_d         = lowerDrop;
         end
      end else begin
         drop_d = lowerDrop || (pushReq && !pushOk);
         if (popReq) begin
            rdPtr_d = rdPtr_q + 2'd1;
         end
         if (pushOk) begin
            mem_d[wrPtr_q] = pushCode;
            wrPtr_d        = wrPtr_q + 2'd1;
         end
         count_d = count_q + 3'(pushOk) - 3'(popReq);
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 28'd0;
         rdPtr_q  <= 2'd0;
         wrPtr_q  <= 2'd0;
         count_q  <= 3'd0;
         mem_q    <= '{default: 2'd0};
         play_q   <= 1'b0;
         evCode_q <= 2'd0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdPtr_q  <= rdPtr_d;
         wrPtr_q  <= wrPtr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
         play_q   <= play_d;
         evCode_q <= evCode_d;
         drop_q   <= drop_d;
      end
   end

   assign bus.play    = play_q;
   assign bus.ev_code = evCode_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.pending = count_q;
   assign bus.drop    = drop_q;

endmodule

// File: tb/tb_sfx_request_queue.sv
// Directed bench for sfx_request_queue with short windows (hold 20, gap 5): a vector table
// for cycle-level FIFO/drop/abort behaviour plus sequences for window timing and reset.
module tb_sfx_request_queue;

   localparam int Hold = 20;
   localparam int Gap  = 5;

   logic clk = 1'b0;
   logic reset;

   sfx_request_queue_if bus();

   sfx_request_queue #(
      .CLK_FREQ   (100_000_000),
      .HOLD_CYCLES(Hold),
      .GAP_CYCLES (Gap)
   ) dut (
      .clk_100MHz(clk),
      .reset     (reset),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ev;
      logic       expPlay;
      logic [1:0] expCode;
      logic       expBusy;
      logic [2:0] expPending;
      logic       expDrop;
   } vec_t;

   vec_t vecs [19];

   int testsRun    = 0;
   int testsFailed = 0;
   int cycle       = 0;
   int lastRise    = 0;
   int lastFall    = 0;
   int riseCount   = 0;
   int dropCount   = 0;
   logic prevPlay  = 1'b0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge, tracking play edges and drop pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
      if (bus.play && !prevPlay) begin
         lastRise = cycle;
         riseCount++;
      end
      if (!bus.play && prevPlay) lastFall = cycle;
      if (bus.drop) dropCount++;
      prevPlay = bus.play;
   endtask

   task automatic applyStimulus(input logic [3:0] ev);
      bus.ev_valid = ev;
      tick();
   endtask

   task automatic waitIdle(input string name, input int budget);
      int guard = 0;
      bus.ev_valid = 4'b0000;
      while ((bus.busy || bus.pending != 3'd0) && guard < budget) begin
         tick();
         guard++;
      end
      checkOutput({name, ".idleReached"}, int'(!bus.busy && bus.pending == 3'd0), 1);
   endtask

   // Called right after a play rise: checks code, hold length and gap length.
   task automatic measureWindow(input string name, input logic [1:0] expCode);
      int guard = 0;
      bus.ev_valid = 4'b0000;
      checkOutput({name, ".code"}, int'(bus.ev_code), int'(expCode));
      while (bus.play && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput({name, ".holdLen"}, lastFall - lastRise, Hold);
      while (bus.busy && guard < 200) begin
         if (bus.ev_code != expCode) checkOutput({name, ".codeHeld"}, int'(bus.ev_code), int'(expCode));
         tick();
         guard++;
      end
      checkOutput({name, ".gapLen"}, cycle - lastFall, Gap);
   endtask

   task automatic checkNextRise(input string name, input logic [1:0] expCode);
      int prevRise = lastRise;
      applyStimulus(4'b0000);
      checkOutput({name, ".play"}, int'(bus.play), 1);
      checkOutput({name, ".code"}, int'(bus.ev_code), int'(expCode));
      checkOutput({name, ".spacing"}, lastRise - prevRise, Hold + Gap + 1);
   endtask

   initial begin
      int baseRises;
      int baseDrops;

      // ev, play, code, busy, pending, drop (state after the edge that samples ev)
      vecs[0]  = '{4'b0110, 1'b0, 2'd0, 1'b0, 3'd1, 1'b1};
      vecs[1]  = '{4'b0000, 1'b1, 2'd2, 1'b1, 3'd0, 1'b0};
      vecs[2]  = '{4'b0001, 1'b1, 2'd2, 1'b1, 3'd1, 1'b0};
      vecs[3]  = '{4'b0001, 1'b1, 2'd2, 1'b1, 3'd2, 1'b0};
      vecs[4]  = '{4'b0011, 1'b1, 2'd2, 1'b1, 3'd3, 1'b1};
      vecs[5]  = '{4'b0001, 1'b1, 2'd2, 1'b1, 3'd4, 1'b0};
      vecs[6]  = '{4'b0001, 1'b1, 2'd2, 1'b1, 3'd4, 1'b1};
      vecs[7]  = '{4'b0100, 1'b1, 2'd2, 1'b1, 3'd4, 1'b1};
      vecs[8]  = '{4'b0000, 1'b1, 2'd2, 1'b1, 3'd4, 1'b0};
      vecs[9]  = '{4'b1000, 1'b0, 2'd2, 1'b1, 3'd1, 1'b0};
      vecs[10] = '{4'b1000, 1'b0, 2'd2, 1'b1, 3'd1, 1'b0};
      vecs[11] = '{4'b0000, 1'b0, 2'd2, 1'b1, 3'd1, 1'b0};
      vecs[12] = '{4'b0000, 1'b0, 2'd2, 1'b1, 3'd1, 1'b0};
      vecs[13] = '{4'b0000, 1'b0, 2'd2, 1'b1, 3'd1, 1'b0};
      vecs[14] = '{4'b0000, 1'b0, 2'd2, 1'b0, 3'd1, 1'b0};
      vecs[15] = '{4'b0000, 1'b1, 2'd3, 1'b1, 3'd0, 1'b0};
      vecs[16] = '{4'b1000, 1'b1, 2'd3, 1'b1, 3'd0, 1'b1};
      vecs[17] = '{4'b0001, 1'b1, 2'd3, 1'b1, 3'd1, 1'b0};
      vecs[18] = '{4'b1000, 1'b1, 2'd3, 1'b1, 3'd0, 1'b1};

      reset = 1'b1;
      bus.ev_valid = 4'b0000;
      tick();
      tick();
      checkOutput("reset.play", int'(bus.play), 0);
      checkOutput("reset.code", int'(bus.ev_code), 0);
      checkOutput("reset.busy", int'(bus.busy), 0);
      checkOutput("reset.pending", int'(bus.pending), 0);
      checkOutput("reset.drop", int'(bus.drop), 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].ev);
         checkOutput($sformatf("vec%0d.play", i), int'(bus.play), int'(vecs[i].expPlay));
         checkOutput($sformatf("vec%0d.code", i), int'(bus.ev_code), int'(vecs[i].expCode));
         checkOutput($sformatf("vec%0d.busy", i), int'(bus.busy), int'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d.pending", i), int'(bus.pending), int'(vecs[i].expPending));
         checkOutput($sformatf("vec%0d.drop", i), int'(bus.drop), int'(vecs[i].expDrop));
      end
      waitIdle("afterTable", 100);

      // Single paddle event: one cycle in the FIFO, then a full window.
      applyStimulus(4'b0001);
      checkOutput("single.pending", int'(bus.pending), 1);
      checkOutput("single.playLow", int'(bus.play), 0);
      applyStimulus(4'b0000);
      checkOutput("single.play", int'(bus.play), 1);
      checkOutput("single.pendingPopped", int'(bus.pending), 0);
      measureWindow("single", 2'd0);
      baseRises = riseCount;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("single.noReplay", riseCount - baseRises, 0);

      // Wall, score, wall back to back: three windows 26 cycles apart, no drops.
      baseDrops = dropCount;
      applyStimulus(4'b0010);
      checkOutput("seq3.pending1", int'(bus.pending), 1);
      applyStimulus(4'b0100);
      checkOutput("seq3.firstPlay", int'(bus.play), 1);
      applyStimulus(4'b0010);
      checkOutput("seq3.pendingPeak", int'(bus.pending), 2);
      measureWindow("seq3.w0", 2'd1);
      checkNextRise("seq3.r1", 2'd2);
      measureWindow("seq3.w1", 2'd2);
      checkNextRise("seq3.r2", 2'd1);
      measureWindow("seq3.w2", 2'd1);
      checkOutput("seq3.noDrop", dropCount - baseDrops, 0);
      waitIdle("seq3", 50);

      // Six paddle pulses during PLAY: four queued, two dropped, four more windows.
      applyStimulus(4'b0001);
      applyStimulus(4'b0000);
      baseRises = riseCount;
      baseDrops = dropCount;
      for (int i = 0; i < 6; i++) applyStimulus(4'b0001);
      checkOutput("six.pending", int'(bus.pending), 4);
      checkOutput("six.drops", dropCount - baseDrops, 2);
      waitIdle("six", 400);
      checkOutput("six.windows", riseCount - baseRises, 4);

      // Asynchronous reset mid-PLAY with two events queued.
      applyStimulus(4'b0001);
      applyStimulus(4'b0000);
      applyStimulus(4'b0001);
      applyStimulus(4'b0001);
      bus.ev_valid = 4'b0000;
      checkOutput("rst.prePending", int'(bus.pending), 2);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("rst.play", int'(bus.play), 0);
      checkOutput("rst.pending", int'(bus.pending), 0);
      checkOutput("rst.busy", int'(bus.busy), 0);
      #2;
      reset = 1'b0;
      baseRises = riseCount;
      for (int i = 0; i < 40; i++) tick();
      checkOutput("rst.noPlay", riseCount - baseRises, 0);
      checkOutput("rst.playLow", int'(bus.play), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/sfx_request_queue.md
# sfx_request_queue

Upstream feeder for the tone sequencer. It accepts single-cycle sound event pulses from the Pong game logic (paddle hit, wall hit, score, game over) and buffers them in a 4-entry FIFO. It then issues them one at a time as a level `play` request held for a fixed window, separated by a silent gap. `play` drives the sequencer's play input directly, and `ev_code` tells downstream tone selection which event is sounding.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz; documentation only.
- `HOLD_CYCLES`, 200_000_000: cycles `play` stays high per request (2.0 s, one full tone sequence).
- `GAP_CYCLES`, 10_000_000: cycles `play` stays low after each request (100 ms).
- `clk_100MHz` in 1: system clock; the block has one clock.
- `reset` in 1: asynchronous, active-high reset.
- `ev_valid` in 4: event pulses, same clock domain. bit0 = paddle, bit1 = wall, bit2 = score, bit3 = game_over.
- `play` out 1: registered play request level.
- `ev_code` out 2: code of the event currently or last played (index of its `ev_valid` bit).
- `busy` out 1: high in PLAY or GAP.
- `pending` out 3: FIFO occupancy, 0..4.
- `drop` out 1: one-cycle pulse when an event is discarded.

## Operation
- FIFO: 4 entries of 2 bits, with 2-bit read and write pointers that wrap 3→0. Occupancy is a 3-bit count.
- Each cycle, at most one event is enqueued: the highest set bit of `ev_valid`.
- Any lower set bits in the same cycle are discarded and `drop` pulses once.
- Push when full: the new event is discarded and `drop` pulses.
  - Exception: a pop on the same edge frees a slot, so the push is accepted.
- game_over (`ev_valid[3]`) has priority handling:
  - It flushes the FIFO. The read pointer is set equal to the write pointer, then code 3 is written as the sole entry, giving `pending` = 1.
  - If the state is PLAY with `ev_code` ≠ 3, the request is aborted: `play` goes low on the next edge and the FSM enters GAP with its counter cleared.
  - If the state is PLAY with `ev_code` = 3, the new game_over is discarded (`drop` pulses) and the FIFO is still flushed empty.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if `pending` ≠ 0, pop the head into `ev_code`, set `play` = 1, clear the counter, and go to PLAY. Otherwise stay, with `play` = 0.
  - PLAY: count up. When counter = `HOLD_CYCLES`−1, set `play` = 0, clear the counter, and go to GAP.
  - GAP: count up. When counter = `GAP_CYCLES`−1, go to IDLE.
- Counter: 28 bits, saturating is not needed. Both parameters must be ≥ 1 and < 2^28; a larger value is illegal.
- Reset (at any time, including mid-PLAY): state IDLE, `play` = 0, `ev_code` = 0, `busy` = 0, `pending` = 0, `drop` = 0, pointers 0, counter 0. Queued events are lost.

## Timing
- Event pulse at edge N with FIFO empty and FSM in IDLE:
  - `pending` = 1 after edge N.
  - Pop at edge N+1: `play` = 1 and `ev_code` valid after edge N+1, with `pending` back to 0.
- `play` is high for exactly `HOLD_CYCLES` cycles, then low for at least `GAP_CYCLES` cycles before any next rise.
- Back-to-back queued events: the next `play` rise comes 1 cycle after GAP ends, because IDLE lasts one cycle.
- `ev_code` changes only on the edge where `play` rises. It holds through GAP and IDLE.
- `busy` = 1 from the `play` rise through the last GAP cycle.
- `drop` is registered: it is high the cycle after the discarding edge, for one cycle per discard event.
- game_over abort: `play` falls on the edge after the `ev_valid[3]` edge. The game_over `play` rises `GAP_CYCLES`+1 cycles after entering GAP.

## Test plan
Run all scenarios with `HOLD_CYCLES` = 20 and `GAP_CYCLES` = 5.

1. Single paddle pulse (`ev_valid` = 0001) at cycle 10 → `play` high in cycles 12..31, `ev_code` = 0, low in cycles 32..36, `busy` = 0 from cycle 37.
2. Wall, score, wall pulses on consecutive cycles while idle → three `play` windows 26 cycles apart, with `ev_code` = 1, 2, 1. `pending` peaks at 2, no `drop`.
3. Six paddle pulses during PLAY → `pending` = 4, `drop` pulses twice, and exactly four further windows play.
4. `ev_valid` = 0110 in one cycle → one entry with code 2 and one `drop` pulse.
5. game_over during PLAY of code 0 with 3 queued → `play` low next cycle, `pending` = 1, the next window has `ev_code` = 3, and nothing plays after it.
6. `reset` asserted mid-PLAY with 2 queued, asynchronously between edges → `play` = 0 and `pending` = 0 immediately. After release, no `play` occurs without new events.
